// File: rtl/dpram_latency_core.sv
// dpram_latency_core: true dual-port RAM with independent fixed write-commit and read-return latencies per port.
// Optional feature: define COLLISION_FLAG_EN to add the registered collision output.
module dpram_latency_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int WR_LATENCYA = 10,
    parameter int RD_LATENCYA = 5,
    parameter int WR_LATENCYB = 7,
    parameter int RD_LATENCYB = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  wr_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  wr_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  valid_b
`ifdef COLLISION_FLAG_EN
    ,
    output logic                  collision
`endif
);
    function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
        return (MEM_DEPTH == (1 << ADDR_WIDTH)) || ({1'b0, a} < (ADDR_WIDTH+1)'(MEM_DEPTH));
    endfunction

    logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];
    logic [WR_LATENCYA-1:0] r_wv_a;
    logic [ADDR_WIDTH-1:0]  r_wa_a [WR_LATENCYA];
    logic [DATA_WIDTH-1:0]  r_wd_a [WR_LATENCYA];
    logic [RD_LATENCYA-1:0] r_rv_a;
    logic [DATA_WIDTH-1:0]  r_rd_a [RD_LATENCYA];
    logic [WR_LATENCYB-1:0] r_wv_b;
    logic [ADDR_WIDTH-1:0]  r_wa_b [WR_LATENCYB];
    logic [DATA_WIDTH-1:0]  r_wd_b [WR_LATENCYB];
    logic [RD_LATENCYB-1:0] r_rv_b;
    logic [DATA_WIDTH-1:0]  r_rd_b [RD_LATENCYB];
    logic [DATA_WIDTH-1:0]  r_dout_a, r_dout_b;
    logic                   r_valid_a, r_valid_b;

    logic                  w_cv_a, w_cv_b, w_rs_a, w_rs_b;
    logic [ADDR_WIDTH-1:0] w_ca_a, w_ca_b;
    logic [DATA_WIDTH-1:0] w_cd_a, w_cd_b, w_rdat_a, w_rdat_b;

    assign w_ca_a   = r_wa_a[WR_LATENCYA-1];
    assign w_cd_a   = r_wd_a[WR_LATENCYA-1];
    assign w_cv_a   = r_wv_a[WR_LATENCYA-1] & in_rng(w_ca_a);
    assign w_ca_b   = r_wa_b[WR_LATENCYB-1];
    assign w_cd_b   = r_wd_b[WR_LATENCYB-1];
    assign w_cv_b   = r_wv_b[WR_LATENCYB-1] & in_rng(w_ca_b);
    assign w_rs_a   = en_a & ~wr_a;
    assign w_rs_b   = en_b & ~wr_b;
    assign w_rdat_a = in_rng(addr_a) ? r_mem[addr_a] : '0;
    assign w_rdat_b = in_rng(addr_b) ? r_mem[addr_b] : '0;
    assign dout_a   = r_dout_a;
    assign valid_a  = r_valid_a;
    assign dout_b   = r_dout_b;
    assign valid_b  = r_valid_b;

    // Array commit: A is applied last so it wins a same-address, same-edge commit
    always_ff @(posedge clk) begin
        if (w_cv_b) r_mem[w_ca_b] <= w_cd_b;
        if (w_cv_a) r_mem[w_ca_a] <= w_cd_a;
    end

    // Port A write/read pipelines and result register; reset flushes everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv_a    <= '0;
            r_rv_a    <= '0;
            r_dout_a  <= '0;
            r_valid_a <= 1'b0;
            for (int i = 0; i < WR_LATENCYA; i++) begin
                r_wa_a[i] <= '0;
                r_wd_a[i] <= '0;
            end
            for (int i = 0; i < RD_LATENCYA; i++) r_rd_a[i] <= '0;
        end else begin
            r_wv_a[0] <= en_a & wr_a;
            r_wa_a[0] <= addr_a;
            r_wd_a[0] <= din_a;
            for (int i = 1; i < WR_LATENCYA; i++) begin
                r_wv_a[i] <= r_wv_a[i-1];
                r_wa_a[i] <= r_wa_a[i-1];
                r_wd_a[i] <= r_wd_a[i-1];
            end
            r_rv_a[0] <= w_rs_a;
            r_rd_a[0] <= w_rdat_a;
            for (int i = 1; i < RD_LATENCYA; i++) begin
                r_rv_a[i] <= r_rv_a[i-1];
                r_rd_a[i] <= r_rd_a[i-1];
            end
            r_valid_a <= r_rv_a[RD_LATENCYA-1];
            if (r_rv_a[RD_LATENCYA-1]) r_dout_a <= r_rd_a[RD_LATENCYA-1];
        end
    end

    // Port B write/read pipelines and result register; reset flushes everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv_b    <= '0;
            r_rv_b    <= '0;
            r_dout_b  <= '0;
            r_valid_b <= 1'b0;
            for (int i = 0; i < WR_LATENCYB; i++) begin
                r_wa_b[i] <= '0;
                r_wd_b[i] <= '0;
            end
            for (int i = 0; i < RD_LATENCYB; i++) r_rd_b[i] <= '0;
        end else begin
            r_wv_b[0] <= en_b & wr_b;
            r_wa_b[0] <= addr_b;
            r_wd_b[0] <= din_b;
            for (int i = 1; i < WR_LATENCYB; i++) begin
                r_wv_b[i] <= r_wv_b[i-1];
                r_wa_b[i] <= r_wa_b[i-1];
                r_wd_b[i] <= r_wd_b[i-1];
            end
            r_rv_b[0] <= w_rs_b;
            r_rd_b[0] <= w_rdat_b;
            for (int i = 1; i < RD_LATENCYB; i++) begin
                r_rv_b[i] <= r_rv_b[i-1];
                r_rd_b[i] <= r_rd_b[i-1];
            end
            r_valid_b <= r_rv_b[RD_LATENCYB-1];
            if (r_rv_b[RD_LATENCYB-1]) r_dout_b <= r_rd_b[RD_LATENCYB-1];
        end
    end

`ifdef COLLISION_FLAG_EN
    logic r_coll;

    // Flag same-edge write/write or read-sample/write commits to one address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_coll <= 1'b0;
        else r_coll <= (w_cv_a & w_cv_b & (w_ca_a == w_ca_b)) |
                       (w_rs_a & w_cv_b & (addr_a == w_ca_b)) |
                       (w_rs_b & w_cv_a & (addr_b == w_ca_a));
    end

    assign collision = r_coll;
`endif
endmodule

// File: doc/dpram_latency_core.md
Name: dpram_latency_core

Overview:
- True dual-port RAM that consumes the pkg_2 latency and width parameters.
- Ports A and B each accept one read or one write request per cycle.
- Writes commit to the array a fixed WR_LATENCYx cycles after acceptance; read data returns RD_LATENCYx cycles after acceptance.
- Sits directly downstream of the parameter package and is the DUT the latency testbench drives.

Parameters:
- DATA_WIDTH, 8, data/word width.
- MEM_DEPTH, 16, number of words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- WR_LATENCYA, 10, port A write commit latency in cycles (>=1).
- RD_LATENCYA, 5, port A read return latency in cycles (>=1).
- WR_LATENCYB, 7, port B write commit latency in cycles (>=1).
- RD_LATENCYB, 8, port B read return latency in cycles (>=1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_a  in  1  port A request valid.
- wr_a  in  1  port A 1=write, 0=read; qualified by en_a.
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data.
- valid_a  out  1  one-cycle pulse marking a new dout_a.
- en_b, wr_b, addr_b, din_b, dout_b, valid_b: identical set for port B.
- collision  out  1  present only when COLLISION_FLAG_EN is defined.

Behaviour:
- Request accepted at edge k when en_x=1; no backpressure, one request per port per cycle.
- Write pipeline: addr/data shift through WR_LATENCYx stages; the array updates at edge k+WR_LATENCYx.
- Read pipeline:
  - The array is sampled at edge k and sees every commit made at edges < k (read-before-write against a commit at the same edge).
  - The data travels RD_LATENCYx-1 further stages.
  - dout_x is updated and valid_x=1 during the cycle after edge k+RD_LATENCYx.
- dout_x holds its last value until the next read result. valid_x=0 in cycles with no result.
- Back-to-back requests are fully pipelined: N consecutive reads give N consecutive valid pulses in request order.
- Same-edge write commits from A and B to one address: port A's data is stored; port B's write is dropped.
- Commits to different addresses in the same edge: both are stored.
- Port A read and port B commit (or the reverse) to one address in the same edge: the read returns the old data.
- Address is in range by construction; when MEM_DEPTH is not a power of two, addr >= MEM_DEPTH writes are ignored and reads return 0.
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - dout_a, dout_b = 0; valid_a, valid_b = 0; collision = 0.
  - All in-flight write and read pipeline stages are flushed, so pending writes never commit.
  - Array contents are NOT reset (undefined after power-up).
- Reset mid-operation: any request accepted before reset assertion has no effect after release. The first request accepted after release behaves normally.
- Latency of 1: a single stage, with no zero-stage shortcut.

Optional Feature:
- Macro: COLLISION_FLAG_EN.
- Defined:
  - Output collision is 1 for the cycle following any edge where both ports commit writes to the same address.
  - It also fires for a same-edge read sample by one port and write commit by the other to the same address.
  - It is registered and reset to 0.
- Undefined: the collision port and its logic are absent. Data behaviour is identical either way.

Test Plan:
- Write then read across ports (defaults): A writes addr 3 = 0x5A at edge 0 (commit edge 10).
  - B read of addr 3 at edge 10 returns the old value, valid_b after edge 18.
  - B read of addr 3 at edge 11 returns 0x5A, valid_b after edge 19.
- Write collision: A writes addr 5 = 0x11 at edge 0, B writes addr 5 = 0x22 at edge 3 (both commit edge 10).
  - A later read of addr 5 returns 0x11.
  - collision=1 for one cycle after edge 10 (macro on).
- Streaming reads: preload addr i = i+0x40 for i = 0..15, then A reads addresses 0..15 on edges 20..35.
  - valid_a is high for 16 consecutive cycles after edges 25..40.
  - dout_a = 0x40..0x4F in order.
- Reset mid-flight: preload addr 7 = 0xAA. A writes addr 7 = 0x33 at edge 0; rst_n low between edges 4 and 5, released before edge 6.
  - dout and valid are 0 immediately on assertion.
  - A read of addr 7 after release returns 0xAA.
- Minimum latency: all latencies = 1. A write at edge k is visible to a read issued at edge k+2; valid follows exactly one cycle after acceptance.
- Simultaneous distinct writes: A writes addr 1 = 0x01 and B writes addr 2 = 0x02, both committing at edge 10.
  - Both values are read back.
  - collision stays 0.
